// File: rtl/uart_pkg.sv
// Definitions shared by both ends of the UART link: FSM state encoding and parity encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Parity bit that should accompany data whose bits XOR to data_xor.
    function automatic logic expected_parity(input logic data_xor, input logic parity_type);
        return data_xor ^ (parity_type == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame configuration in, recovered word and status out.
interface uart_rx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_serial_data;
    logic                  i_parity_enable;
    logic                  i_parity_type;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_data_valid;
    logic                  o_parity_error;
    logic                  o_stop_error;
    logic                  o_busy_flag;

    modport master (
        output i_serial_data, i_parity_enable, i_parity_type,
        input  o_data, o_data_valid, o_parity_error, o_stop_error, o_busy_flag
    );

    modport slave (
        input  i_serial_data, i_parity_enable, i_parity_type,
        output o_data, o_data_valid, o_parity_error, o_stop_error, o_busy_flag
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit tick counter and 3-sample majority vote around the bit centre.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_serial_data,
    input  logic i_restart,
    output logic o_line,
    output logic o_bit,
    output logic o_sample_strobe,
    output logic o_bit_end
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_LO   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_HI   = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

    logic          sync_meta;
    logic          sync_line;
    logic [TW-1:0] tick;
    logic          samp_lo;
    logic          samp_mid;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_meta <= 1'b1;
            sync_line <= 1'b1;
        end else begin
            sync_meta <= i_serial_data;
            sync_line <= sync_meta;
        end
    end

    // Held at zero while the receiver idles, so tick 0 is the cycle the start edge is seen.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_restart) begin
            tick <= '0;
        end else if (tick == T_LAST) begin
            tick <= '0;
        end else begin
            tick <= tick + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            samp_lo  <= 1'b1;
            samp_mid <= 1'b1;
        end else begin
            if (tick == T_LO) begin
                samp_lo <= sync_line;
            end
            if (tick == T_MID) begin
                samp_mid <= sync_line;
            end
        end
    end

    // The third sample is the live line at T_HI; consumers register the vote on that edge.
    always_comb begin
        o_line          = sync_line;
        o_bit           = (samp_lo & samp_mid) | (samp_lo & sync_line) | (samp_mid & sync_line);
        o_sample_strobe = (tick == T_HI);
        o_bit_end       = (tick == T_LAST);
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: frame FSM, data shift register, parity check and registered status pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input logic     i_clk,
    input logic     i_rst,
    uart_rx_if.slave bus
);
    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_state_t           state;
    uart_state_t           state_next;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_en_q;
    logic                  par_type_q;
    logic                  par_err_q;
    logic                  line;
    logic                  bit_val;
    logic                  strobe;
    logic                  bit_end;
    logic                  take_frame;
    logic                  flag_stop;
    logic                  flag_par;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_serial_data  (bus.i_serial_data),
        .i_restart      (state_next == ST_IDLE),
        .o_line         (line),
        .o_bit          (bit_val),
        .o_sample_strobe(strobe),
        .o_bit_end      (bit_end)
    );

    always_comb begin
        state_next = state;
        take_frame = 1'b0;
        flag_stop  = 1'b0;
        flag_par   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!line) state_next = ST_START;
            end
            ST_START: begin
                if (strobe && bit_val) state_next = ST_IDLE;
                else if (bit_end)      state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_idx == LAST_IDX) begin
                    state_next = par_en_q ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                // Resolve at the stop sample so a back-to-back start edge is not missed.
                if (strobe) begin
                    state_next = ST_IDLE;
                    if (!bit_val)      flag_stop  = 1'b1;
                    else if (par_err_q) flag_par  = 1'b1;
                    else               take_frame = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && state_next == ST_START) begin
                par_en_q   <= bus.i_parity_enable;
                par_type_q <= bus.i_parity_type;
                par_err_q  <= 1'b0;
                bit_idx    <= '0;
            end
            if (state == ST_DATA) begin
                if (strobe)  shreg   <= {bit_val, shreg[DATA_WIDTH-1:1]};
                if (bit_end) bit_idx <= bit_idx + 1'b1;
            end
            if (state == ST_PARITY && strobe) begin
                par_err_q <= (bit_val != expected_parity(^shreg, par_type_q));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bus.o_data         <= '0;
            bus.o_data_valid   <= 1'b0;
            bus.o_parity_error <= 1'b0;
            bus.o_stop_error   <= 1'b0;
            bus.o_busy_flag    <= 1'b0;
        end else begin
            bus.o_data_valid   <= take_frame;
            bus.o_parity_error <= flag_par;
            bus.o_stop_error   <= flag_stop;
            bus.o_busy_flag    <= (state_next != ST_IDLE);
            if (take_frame) bus.o_data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random frames against a frame-level model.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int OS = 8;
    localparam int EV_VALID  = 1;
    localparam int EV_PARITY = 2;
    localparam int EV_STOP   = 3;

    typedef struct {
        int         kind;
        int         cyc;
        logic [7:0] data;
    } ev_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] last_good = 8'h00;
    ev_t        evq[$];
    ev_t        expq[$];

    uart_rx_if #(.DATA_WIDTH(8)) bus ();

    uart_rx #(
        .DATA_WIDTH(8),
        .OVERSAMPLE(OS)
    ) dut (
        .i_clk(clock),
        .i_rst(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Every status pulse is logged with the cycle it was seen in and the word on o_data.
    always @(negedge clock) begin
        if (bus.o_data_valid === 1'b1)   evq.push_back('{EV_VALID, cyc, bus.o_data});
        if (bus.o_parity_error === 1'b1) evq.push_back('{EV_PARITY, cyc, bus.o_data});
        if (bus.o_stop_error === 1'b1)   evq.push_back('{EV_STOP, cyc, bus.o_data});
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached (actual running, required finished)");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic ev_t model_frame(input logic [7:0] d, input logic pen, input logic ptype,
                                        input logic pbit, input logic sbit, input int start,
                                        input logic [7:0] held);
        ev_t e;
        int  ones;
        ones   = $countones(d) + ((pen && pbit) ? 1 : 0);
        e.cyc  = start + (9 + (pen ? 1 : 0)) * OS + OS / 2 + 4;
        e.data = held;
        if (!sbit) begin
            e.kind = EV_STOP;
        end else if (pen && ((ones % 2) != (ptype ? 1 : 0))) begin
            e.kind = EV_PARITY;
        end else begin
            e.kind = EV_VALID;
            e.data = d;
        end
        return e;
    endfunction

    function automatic logic good_parity(input logic [7:0] d, input logic ptype);
        return 1'(($countones(d) + (ptype ? 1 : 0)) % 2);
    endfunction

    task automatic hold_line(input logic v, input int n);
        bus.i_serial_data = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Sends one frame using the current DUT configuration; flip_at toggles parity enable mid-frame.
    task automatic run_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int flip_at);
        logic bits[$];
        logic pen;
        logic ptype;
        int   start;
        ev_t  e;
        pen   = bus.i_parity_enable;
        ptype = bus.i_parity_type;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(sbit);
        start = cyc;
        e = model_frame(d, pen, ptype, pbit, sbit, start, last_good);
        expq.push_back(e);
        if (e.kind == EV_VALID) last_good = d;
        for (int i = 0; i < bits.size(); i++) begin
            if (flip_at >= 0 && (i == flip_at || i == bits.size() - 1)) begin
                bus.i_parity_enable = !bus.i_parity_enable;
            end
            hold_line(bits[i], OS);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        vectors++;
        if (bus.o_data !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got %h expected 00", bus.o_data);
        end
        vectors++;
        if ({bus.o_data_valid, bus.o_parity_error, bus.o_stop_error} !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL reset_pulses: got %b expected 000",
                     {bus.o_data_valid, bus.o_parity_error, bus.o_stop_error});
        end
        vectors++;
        if (bus.o_busy_flag !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_busy: got %b expected 0", bus.o_busy_flag);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        hold_line(1'b1, 4);
    endtask

    task automatic test_no_parity();
        evq.delete();
        expq.delete();
        bus.i_parity_enable = 1'b0;
        run_frame(8'hA5, 1'b0, 1'b1, -1);
        hold_line(1'b1, 12);
        vectors++;
        if (evq.size() != expq.size()) begin
            miscompares++;
            $display("[TB] FAIL no_parity_count: got %0d events expected %0d", evq.size(), expq.size());
        end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            vectors++;
            if (evq[i].kind !== expq[i].kind || evq[i].cyc !== expq[i].cyc || evq[i].data !== expq[i].data) begin
                miscompares++;
                $display("[TB] FAIL no_parity_event%0d: got kind %0d cyc %0d data %h expected kind %0d cyc %0d data %h",
                         i, evq[i].kind, evq[i].cyc, evq[i].data, expq[i].kind, expq[i].cyc, expq[i].data);
            end
        end
    endtask

    task automatic test_parity();
        evq.delete();
        expq.delete();
        bus.i_parity_enable = 1'b1;
        bus.i_parity_type   = PARITY_EVEN;
        run_frame(8'h3C, 1'b0, 1'b1, -1);
        hold_line(1'b1, 12);
        run_frame(8'h3C, 1'b1, 1'b1, -1);
        hold_line(1'b1, 12);
        bus.i_parity_type   = PARITY_ODD;
        run_frame(8'h81, 1'b1, 1'b0, -1);
        hold_line(1'b1, 16);
        vectors++;
        if (evq.size() != expq.size()) begin
            miscompares++;
            $display("[TB] FAIL parity_count: got %0d events expected %0d", evq.size(), expq.size());
        end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            vectors++;
            if (evq[i].kind !== expq[i].kind || evq[i].cyc !== expq[i].cyc || evq[i].data !== expq[i].data) begin
                miscompares++;
                $display("[TB] FAIL parity_event%0d: got kind %0d cyc %0d data %h expected kind %0d cyc %0d data %h",
                         i, evq[i].kind, evq[i].cyc, evq[i].data, expq[i].kind, expq[i].cyc, expq[i].data);
            end
        end
    endtask

    task automatic test_glitch();
        int busy_rise;
        int busy_fall;
        logic exp_busy;
        // Busy follows start detection (2 sync + 1 cycles) and drops where a 0-bit frame would resolve.
        busy_rise = 3;
        busy_fall = OS / 2 + 4;
        evq.delete();
        expq.delete();
        bus.i_parity_enable = 1'b0;
        for (int i = 0; i < 14; i++) begin
            bus.i_serial_data = (i < 2) ? 1'b0 : 1'b1;
            @(negedge clock);
            exp_busy = (i >= busy_rise && i < busy_fall);
            vectors++;
            if (bus.o_busy_flag !== exp_busy) begin
                miscompares++;
                $display("[TB] FAIL glitch_busy_t%0d: got %b expected %b", i, bus.o_busy_flag, exp_busy);
            end
            @(posedge clock);
            #1;
        end
        vectors++;
        if (evq.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL glitch_no_pulse: got %0d events expected 0", evq.size());
        end
        evq.delete();
        run_frame(8'h42, 1'b0, 1'b1, -1);
        hold_line(1'b1, 12);
        vectors++;
        if (evq.size() != 1 || evq[0].kind !== expq[0].kind || evq[0].cyc !== expq[0].cyc || evq[0].data !== expq[0].data) begin
            miscompares++;
            $display("[TB] FAIL glitch_followup: got %0d events, first data %h expected one valid %h at cyc %0d",
                     evq.size(), (evq.size() > 0) ? evq[0].data : 8'hxx, expq[0].data, expq[0].cyc);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        d = 8'h77;
        bus.i_parity_enable = 1'b0;
        hold_line(1'b0, OS);
        for (int i = 0; i < 3; i++) hold_line(d[i], OS);
        hold_line(d[3], 3);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        vectors++;
        if ({bus.o_data, bus.o_data_valid, bus.o_parity_error, bus.o_stop_error, bus.o_busy_flag} !== 12'h000) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_outputs: got data %h valid %b perr %b serr %b busy %b expected all 0",
                     bus.o_data, bus.o_data_valid, bus.o_parity_error, bus.o_stop_error, bus.o_busy_flag);
        end
        hold_line(1'b1, 1);
        reset = 1'b0;
        last_good = 8'h00;
        evq.delete();
        expq.delete();
        hold_line(1'b1, 20);
        vectors++;
        if (evq.size() != 0 || bus.o_busy_flag !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_quiet: got %0d events busy %b expected 0 events busy 0",
                     evq.size(), bus.o_busy_flag);
        end
        run_frame(8'h5A, 1'b0, 1'b1, -1);
        hold_line(1'b1, 12);
        vectors++;
        if (evq.size() != 1 || evq[0].kind !== expq[0].kind || evq[0].cyc !== expq[0].cyc || evq[0].data !== expq[0].data) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset_followup: got %0d events, first data %h expected one valid %h at cyc %0d",
                     evq.size(), (evq.size() > 0) ? evq[0].data : 8'hxx, expq[0].data, expq[0].cyc);
        end
    endtask

    task automatic test_back_to_back();
        evq.delete();
        expq.delete();
        bus.i_parity_enable = 1'b0;
        run_frame(8'h01, 1'b0, 1'b1, 4);
        run_frame(8'hFF, 1'b0, 1'b1, -1);
        hold_line(1'b1, 12);
        vectors++;
        if (evq.size() != expq.size()) begin
            miscompares++;
            $display("[TB] FAIL b2b_count: got %0d events expected %0d", evq.size(), expq.size());
        end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            vectors++;
            if (evq[i].kind !== expq[i].kind || evq[i].cyc !== expq[i].cyc || evq[i].data !== expq[i].data) begin
                miscompares++;
                $display("[TB] FAIL b2b_event%0d: got kind %0d cyc %0d data %h expected kind %0d cyc %0d data %h",
                         i, evq[i].kind, evq[i].cyc, evq[i].data, expq[i].kind, expq[i].cyc, expq[i].data);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       pbit;
        logic       sbit;
        evq.delete();
        expq.delete();
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            bus.i_parity_enable = 1'($urandom);
            bus.i_parity_type   = 1'($urandom);
            pbit = good_parity(d, bus.i_parity_type);
            if ($urandom_range(0, 3) == 0) pbit = !pbit;
            sbit = ($urandom_range(0, 7) != 0);
            run_frame(d, pbit, sbit, -1);
            hold_line(1'b1, sbit ? $urandom_range(0, 3) : 16);
        end
        hold_line(1'b1, 12);
        vectors++;
        if (evq.size() != expq.size()) begin
            miscompares++;
            $display("[TB] FAIL random_count: got %0d events expected %0d", evq.size(), expq.size());
        end
        for (int i = 0; i < evq.size() && i < expq.size(); i++) begin
            vectors++;
            if (evq[i].kind !== expq[i].kind || evq[i].cyc !== expq[i].cyc || evq[i].data !== expq[i].data) begin
                miscompares++;
                $display("[TB] FAIL random_event%0d: got kind %0d cyc %0d data %h expected kind %0d cyc %0d data %h",
                         i, evq[i].kind, evq[i].cyc, evq[i].data, expq[i].kind, expq[i].cyc, expq[i].data);
            end
        end
    endtask

    initial begin
        bus.i_serial_data   = 1'b1;
        bus.i_parity_enable = 1'b0;
        bus.i_parity_type   = PARITY_EVEN;
        test_reset();
        test_no_parity();
        test_parity();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
